// File: rtl/mp3_mon_pkg.sv
// Shared definitions for the mp3 pipeline stage monitor: read-port select
// encoding, per-stage FSM states and the per-stage status word layout.
package mp3_mon_pkg;

  // Low two bits of the read address select which statistic is returned
  localparam logic [1:0] SEL_LAST   = 2'd0;
  localparam logic [1:0] SEL_MAX    = 2'd1;
  localparam logic [1:0] SEL_RUNS   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } stage_state_e;

  // Per-stage status bits; occupies the top of the status read word
  typedef struct packed {
    logic stall;
    logic busy;
  } stage_status_t;

endpackage

// File: rtl/mp3_stage_timer.sv
// Single-stage activity timer: detects edges of an active-low-while-busy
// done line, measures busy length (last/max), counts completed runs and
// raises a sticky stall flag when a run exceeds the watchdog limit.
module mp3_stage_timer
  import mp3_mon_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_done,
  input  logic             i_clr_stall,
  output logic             o_start,
  output logic             o_finish,
  output logic             o_stall,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_last,
  output logic [CNT_W-1:0] o_max,
  output logic [CNT_W-1:0] o_runs
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [63:0]      TIMEOUT_64 = 64'(TIMEOUT_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  stage_state_e     r_state;
  stage_state_e     w_state_nxt;
  logic             r_prev;
  logic             r_start;
  logic             r_finish;
  logic             r_stall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_last;
  logic [CNT_W-1:0] r_max;
  logic [CNT_W-1:0] r_runs;
  logic             w_start;
  logic             w_finish;
  logic             w_hit_timeout;

  assign w_start  = r_prev & ~i_done;
  assign w_finish = ~r_prev & i_done;

  // Next state and busy counter; the counter restarts at 1 on the start edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      ST_BUSY: begin
        if (w_finish) begin
          w_state_nxt = ST_IDLE;
        end else if (!i_done) begin
          w_cnt_nxt = sat_inc(r_cnt);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog fires on the cycle the busy count reaches the limit
  assign w_hit_timeout = (TIMEOUT_CYC != 0) && (w_state_nxt == ST_BUSY) &&
                         (64'(w_cnt_nxt) == TIMEOUT_64);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Edge history and registered start/finish pulses; history resets to idle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev   <= 1'b1;
      r_start  <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_prev   <= i_done;
      r_start  <= w_start;
      r_finish <= w_finish;
    end
  end

  // Busy counter, run statistics and sticky stall flag
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_last  <= '0;
      r_max   <= '0;
      r_runs  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (r_state == ST_BUSY && w_finish) begin
        r_last <= r_cnt;
        if (r_cnt > r_max) r_max <= r_cnt;
        r_runs <= sat_inc(r_runs);
      end
      // A new stall takes priority over a coincident read-to-clear
      if (w_hit_timeout)    r_stall <= 1'b1;
      else if (i_clr_stall) r_stall <= 1'b0;
    end
  end

  assign o_start  = r_start;
  assign o_finish = r_finish;
  assign o_stall  = r_stall;
  assign o_busy   = (r_state == ST_BUSY);
  assign o_last   = r_last;
  assign o_max    = r_max;
  assign o_runs   = r_runs;

endmodule

// File: rtl/mp3_stage_monitor.sv
// Activity monitor for the mp3 decoder pipeline stages. One timer per stage
// plus a wrapping frame counter and a registered statistics read port.
// Optional macro MP3_STAGE_MONITOR_TRACE_EN adds a simulation-only trace
// printer; logic behaviour is the same with or without it.
module mp3_stage_monitor
  import mp3_mon_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int CNT_W       = 24,
  parameter int FRAME_W     = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic                  frame_tick,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [NUM_STAGES-1:0] stage_finish,
  output logic [FRAME_W-1:0]    frame_count,
  output logic [NUM_STAGES-1:0] stall_flag,
  input  logic                  rd_en,
  input  logic [4:0]            rd_addr,
  output logic [CNT_W-1:0]      rd_data,
  output logic                  rd_valid
);

  logic [CNT_W-1:0]      w_last [NUM_STAGES];
  logic [CNT_W-1:0]      w_max  [NUM_STAGES];
  logic [CNT_W-1:0]      w_runs [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_busy;
  logic [NUM_STAGES-1:0] w_clr_stall;
  logic [2:0]            w_rd_stage;
  logic [1:0]            w_rd_sel;
  logic [CNT_W-1:0]      w_rd_word;
  stage_status_t         w_status;
  logic [FRAME_W-1:0]    r_frame_cnt;
  logic [CNT_W-1:0]      r_rd_data;
  logic                  r_rd_valid;

  assign w_rd_stage = rd_addr[4:2];
  assign w_rd_sel   = rd_addr[1:0];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    assign w_clr_stall[g] = rd_en && (w_rd_sel == SEL_STATUS) && (w_rd_stage == 3'(g));

    mp3_stage_timer #(
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
      .clock       (clock),
      .reset       (reset),
      .i_done      (stage_done[g]),
      .i_clr_stall (w_clr_stall[g]),
      .o_start     (stage_start[g]),
      .o_finish    (stage_finish[g]),
      .o_stall     (stall_flag[g]),
      .o_busy      (w_busy[g]),
      .o_last      (w_last[g]),
      .o_max       (w_max[g]),
      .o_runs      (w_runs[g])
    );
  end

  // Frame counter wraps; reset has priority over a coincident tick
  always_ff @(posedge clock) begin
    if (reset)           r_frame_cnt <= '0;
    else if (frame_tick) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
  end

  // Read mux; unpopulated stage indices fall through to zero
  always_comb begin
    w_rd_word = '0;
    w_status  = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (w_rd_stage == 3'(i)) begin
        w_status.stall = stall_flag[i];
        w_status.busy  = w_busy[i];
        case (w_rd_sel)
          SEL_LAST:   w_rd_word = w_last[i];
          SEL_MAX:    w_rd_word = w_max[i];
          SEL_RUNS:   w_rd_word = w_runs[i];
          default:    w_rd_word = {w_status, (CNT_W-2)'(0)};
        endcase
      end
    end
  end

  // Registered read response; captures values before this cycle's updates
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_word;
    end
  end

  assign frame_count = r_frame_cnt;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;

`ifdef MP3_STAGE_MONITOR_TRACE_EN
`ifndef SYNTHESIS
  // Print stage start/finish and frame progress as they occur
  always @(posedge clock) begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (stage_start[i])  $write("stage %0d started...\n", i);
      if (stage_finish[i]) $write("stage %0d finished... (%0d cycles)\n", i, w_last[i]);
    end
    if (frame_tick && !reset) $write("current frame: %0d\n", r_frame_cnt + 1);
  end
`endif
`else
  // Trace printer not built
`endif

endmodule

// File: tb/tb_mp3_stage_monitor.sv
// Bench for mp3_stage_monitor: drives stage done lines, frame ticks and
// register reads; read results are checked through an expectation queue.
module tb_mp3_stage_monitor;

  localparam int NS = 4;
  localparam int CW = 24;
  localparam int FW = 16;
  localparam int TO = 100;
  localparam logic [CW-1:0] ST_STALL = 24'h800000;
  localparam logic [CW-1:0] ST_BUSYW = 24'h400000;

  logic          clock = 1'b0;
  logic          reset;
  logic [NS-1:0] stage_done;
  logic          frame_tick;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_finish;
  logic [FW-1:0] frame_count;
  logic [NS-1:0] stall_flag;
  logic          rd_en;
  logic [4:0]    rd_addr;
  logic [CW-1:0] rd_data;
  logic          rd_valid;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW-1:0] exp_q [$];

  typedef struct {
    int            phase;
    int            stage;
    int            sel;
    logic [CW-1:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [$];

  always #5 clock = ~clock;

  mp3_stage_monitor #(
    .NUM_STAGES  (NS),
    .CNT_W       (CW),
    .FRAME_W     (FW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stage_done   (stage_done),
    .frame_tick   (frame_tick),
    .stage_start  (stage_start),
    .stage_finish (stage_finish),
    .frame_count  (frame_count),
    .stall_flag   (stall_flag),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Read responses: pop the oldest expectation whenever rd_valid is seen
  always @(negedge clock) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_valid_unexpected: actual rd_data %0d required no response", rd_data);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  // Issue one read at a negedge; returns at the negedge where the response is checked
  task automatic do_read(input int s, input int sel, input logic [CW-1:0] exp);
    rd_addr = {s[2:0], sel[1:0]};
    rd_en   = 1'b1;
    exp_q.push_back(exp);
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic apply_phase(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) do_read(vecs[i].stage, vecs[i].sel, vecs[i].exp);
    end
  endtask

  // Hold stage s busy for n sampled cycles, checking pulses and watchdog
  task automatic run_busy(input int s, input int n);
    stage_done[s] = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clock);
      if (k == 1) begin
        check("stage_start", stage_start, 64'(1) << s);
        check("no_finish_at_start", stage_finish, 0);
      end else if (k == 2) begin
        check("start_one_cycle", stage_start, 0);
      end
      if (n >= TO && k == TO - 1) check("stall_before_limit", stall_flag[s], 0);
      if (n >= TO && k == TO)     check("stall_at_limit", stall_flag[s], 1);
      if (k == n) stage_done[s] = 1'b1;
    end
    @(negedge clock);
    check("stage_finish", stage_finish, 64'(1) << s);
    @(negedge clock);
    check("finish_one_cycle", stage_finish, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required test completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset      = 1'b1;
    stage_done = '1;
    frame_tick = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;

    for (int s = 0; s < NS; s++)
      for (int sel = 0; sel < 4; sel++)
        vecs.push_back('{0, s, sel, 24'd0});
    vecs.push_back('{0, 5, 0, 24'd0});
    vecs.push_back('{0, 7, 3, 24'd0});
    vecs.push_back('{1, 1, 0, 24'd50});
    vecs.push_back('{1, 1, 1, 24'd50});
    vecs.push_back('{1, 1, 2, 24'd1});
    vecs.push_back('{1, 1, 3, 24'd0});
    vecs.push_back('{2, 0, 0, 24'd10});
    vecs.push_back('{2, 0, 1, 24'd30});
    vecs.push_back('{2, 0, 2, 24'd2});
    vecs.push_back('{3, 2, 3, 24'd0});
    vecs.push_back('{3, 2, 0, 24'd150});
    vecs.push_back('{3, 2, 1, 24'd150});
    vecs.push_back('{3, 2, 2, 24'd1});
    for (int sel = 0; sel < 4; sel++) vecs.push_back('{4, 3, sel, 24'd0});
    vecs.push_back('{4, 1, 0, 24'd0});
    vecs.push_back('{4, 2, 1, 24'd0});
    vecs.push_back('{5, 3, 0, 24'd5});
    vecs.push_back('{5, 3, 1, 24'd5});
    vecs.push_back('{5, 3, 2, 24'd1});
    vecs.push_back('{6, 0, 0, 24'd1});
    vecs.push_back('{6, 0, 1, 24'd1});
    vecs.push_back('{6, 0, 2, 24'd1});

    repeat (3) @(negedge clock);
    check("rst_start", stage_start, 0);
    check("rst_finish", stage_finish, 0);
    check("rst_frame", frame_count, 0);
    check("rst_stall", stall_flag, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("post_rst_no_pulse", {stage_start, stage_finish}, 0);
    end
    apply_phase(0);

    run_busy(1, 50);
    apply_phase(1);

    run_busy(0, 30);
    @(negedge clock);
    run_busy(0, 10);
    apply_phase(2);

    run_busy(2, 150);
    check("stall_held_after_finish", stall_flag, 4'b0100);
    do_read(2, 3, ST_STALL);
    check("stall_cleared_by_read", stall_flag, 0);
    apply_phase(3);

    frame_tick = 1'b1;
    repeat (70000) @(negedge clock);
    frame_tick = 1'b0;
    check("frame_wrap", frame_count, 4464);

    stage_done[3] = 1'b0;
    repeat (20) @(negedge clock);
    do_read(3, 3, ST_BUSYW);
    stage_done[3] = 1'b1;
    reset         = 1'b1;
    frame_tick    = 1'b1;
    @(negedge clock);
    check("rst_mid_busy_no_finish", stage_finish, 0);
    check("rst_mid_busy_frame", frame_count, 0);
    reset      = 1'b0;
    frame_tick = 1'b0;
    @(negedge clock);
    check("after_rst_no_pulse", {stage_start, stage_finish}, 0);
    apply_phase(4);

    run_busy(3, 5);
    apply_phase(5);

    run_busy(0, 1);
    apply_phase(6);

    repeat (3) @(negedge clock);
    check("rd_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
